cpu_control_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute FSM for the 16-bit accumulator CPU.

---
 rtl/cpu_control_sequencer_pkg.sv | 51 +++++
 rtl/cpu_control_sequencer_decode.sv | 35 +++
 rtl/cpu_control_sequencer.sv | 161 ++++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_sequencer_pkg.sv
// Shared encodings for the accumulator CPU control sequencer: opcodes, ALU codes,
// instruction classes and the binary FSM state encoding.
package cpu_control_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_FETCH_ADDR = 4'd1,
    ST_FETCH_MEM  = 4'd2,
    ST_FETCH_IR   = 4'd3,
    ST_DECODE     = 4'd4,
    ST_EXEC_ADDR  = 4'd5,
    ST_EXEC_MEM   = 4'd6,
    ST_EXEC_WB    = 4'd7,
    ST_HALTED     = 4'd8
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_SHL   = 4'h8;
  localparam logic [3:0] OP_SHR   = 4'h9;
  localparam logic [3:0] OP_JUMP  = 4'hA;
  localparam logic [3:0] OP_JMPZ  = 4'hB;
  localparam logic [3:0] OP_JMPN  = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b1000;
  localparam logic [3:0] ALU_OR  = 4'b1001;
  localparam logic [3:0] ALU_XOR = 4'b1010;
  localparam logic [3:0] ALU_SHL = 4'b0100;
  localparam logic [3:0] ALU_SHR = 4'b0101;

  // Instruction classes: what the sequencer does after DECODE.
  localparam logic [3:0] CL_NOP   = 4'd0;
  localparam logic [3:0] CL_LOAD  = 4'd1;
  localparam logic [3:0] CL_STORE = 4'd2;
  localparam logic [3:0] CL_ALU   = 4'd3;
  localparam logic [3:0] CL_SHIFT = 4'd4;
  localparam logic [3:0] CL_JUMP  = 4'd5;
  localparam logic [3:0] CL_JMPZ  = 4'd6;
  localparam logic [3:0] CL_JMPN  = 4'd7;
  localparam logic [3:0] CL_HALT  = 4'd8;

endpackage

// File: rtl/cpu_control_sequencer_decode.sv
// Combinational opcode decode: IR[15:12] to instruction class, ALU function and
// an illegal flag. Reserved opcodes decode as HALT with illegal set.
module cpu_control_sequencer_decode
  import cpu_control_sequencer_pkg::*;
(
  input  logic [3:0] ir_opcode,
  output logic [3:0] op_class,
  output logic [3:0] alu_op,
  output logic       illegal
);

  always_comb begin
    op_class = CL_HALT;
    alu_op   = ALU_ADD;
    illegal  = 1'b0;
    case (ir_opcode)
      OP_NOP:   op_class = CL_NOP;
      OP_LOAD:  op_class = CL_LOAD;
      OP_STORE: op_class = CL_STORE;
      OP_ADD:   begin op_class = CL_ALU;   alu_op = ALU_ADD; end
      OP_SUB:   begin op_class = CL_ALU;   alu_op = ALU_SUB; end
      OP_AND:   begin op_class = CL_ALU;   alu_op = ALU_AND; end
      OP_OR:    begin op_class = CL_ALU;   alu_op = ALU_OR;  end
      OP_XOR:   begin op_class = CL_ALU;   alu_op = ALU_XOR; end
      OP_SHL:   begin op_class = CL_SHIFT; alu_op = ALU_SHL; end
      OP_SHR:   begin op_class = CL_SHIFT; alu_op = ALU_SHR; end
      OP_JUMP:  op_class = CL_JUMP;
      OP_JMPZ:  op_class = CL_JMPZ;
      OP_JMPN:  op_class = CL_JMPN;
      OP_HALT:  op_class = CL_HALT;
      default:  begin op_class = CL_HALT; illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator CPU.
// Memory handshake: an access is issued by holding mem_read or mem_write; it completes in the cycle mem_ready is 1.
module cpu_control_sequencer
  import cpu_control_sequencer_pkg::*;
#(
  parameter bit AUTO_START = 1'b0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] ir_opcode,
  input  logic       acc_zero,
  input  logic       acc_neg,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mar_write,
  output logic       mar_src,
  output logic       mbr_write,
  output logic       mbr_src,
  output logic       ir_write,
  output logic       pc_inc,
  output logic       pc_write,
  output logic       acc_write,
  output logic       acc_src,
  output logic [3:0] alu_op,
  output logic       retire,
  output logic       halted,
  output logic       illegal,
  output logic [3:0] state
);

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] op_class;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;
  logic       branch_taken;

  cpu_control_sequencer_decode u_decode (
    .ir_opcode (ir_opcode),
    .op_class  (op_class),
    .alu_op    (dec_alu_op),
    .illegal   (dec_illegal)
  );

  assign branch_taken = (op_class == CL_JUMP) ||
                        ((op_class == CL_JMPZ) && acc_zero) ||
                        ((op_class == CL_JMPN) && acc_neg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE:       if (start || AUTO_START) state_d = ST_FETCH_ADDR;
      ST_FETCH_ADDR: state_d = ST_FETCH_MEM;
      ST_FETCH_MEM:  if (mem_ready) state_d = ST_FETCH_IR;
      ST_FETCH_IR:   state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CL_NOP, CL_JUMP, CL_JMPZ, CL_JMPN: state_d = ST_FETCH_ADDR;
          CL_SHIFT:                          state_d = ST_EXEC_WB;
          CL_HALT: begin
            state_d   = ST_HALTED;
            illegal_d = illegal_q | dec_illegal;
          end
          default:                           state_d = ST_EXEC_ADDR;
        endcase
      end
      ST_EXEC_ADDR:  state_d = ST_EXEC_MEM;
      ST_EXEC_MEM:   if (mem_ready) state_d = (op_class == CL_STORE) ? ST_FETCH_ADDR : ST_EXEC_WB;
      ST_EXEC_WB:    state_d = ST_FETCH_ADDR;
      ST_HALTED: begin
        if (start) begin
          state_d   = ST_FETCH_ADDR;
          illegal_d = 1'b0;
        end
      end
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mar_write = 1'b0;
    mar_src   = 1'b0;
    mbr_write = 1'b0;
    mbr_src   = 1'b0;
    ir_write  = 1'b0;
    pc_inc    = 1'b0;
    pc_write  = 1'b0;
    acc_write = 1'b0;
    acc_src   = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH_ADDR: mar_write = 1'b1;
      ST_FETCH_MEM: begin
        mem_read  = 1'b1;
        mbr_write = mem_ready;
      end
      ST_FETCH_IR: begin
        ir_write = 1'b1;
        pc_inc   = 1'b1;
      end
      ST_DECODE: begin
        case (op_class)
          CL_NOP, CL_JUMP, CL_JMPZ, CL_JMPN: begin
            retire   = 1'b1;
            pc_write = branch_taken;
          end
          CL_HALT: retire = !dec_illegal;
          default: ;
        endcase
      end
      ST_EXEC_ADDR: begin
        mar_write = 1'b1;
        mar_src   = 1'b1;
        if (op_class == CL_STORE) begin
          mbr_write = 1'b1;
          mbr_src   = 1'b1;
        end
      end
      ST_EXEC_MEM: begin
        if (op_class == CL_STORE) begin
          mem_write = 1'b1;
          retire    = mem_ready;
        end else begin
          mem_read  = 1'b1;
          mbr_write = mem_ready;
        end
      end
      ST_EXEC_WB: begin
        acc_write = 1'b1;
        retire    = 1'b1;
        if (op_class != CL_LOAD) begin
          acc_src = 1'b1;
          alu_op  = dec_alu_op;
        end
      end
      ST_HALTED: halted = 1'b1;
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Bench for cpu_control_sequencer: a small datapath/memory model closes the loop and
// a retire scoreboard checks cycle count and writeback controls of each instruction.
module tb_cpu_control_sequencer;
  import cpu_control_sequencer_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ir_opcode;
  logic        acc_zero, acc_neg, mem_ready;
  logic        mem_read, mem_write, mar_write, mar_src, mbr_write, mbr_src;
  logic        ir_write, pc_inc, pc_write, acc_write, acc_src;
  logic [3:0]  alu_op;
  logic        retire, halted, illegal;
  logic [3:0]  state;

  always #5 clock = ~clock;

  cpu_control_sequencer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .ir_opcode (ir_opcode),
    .acc_zero  (acc_zero),
    .acc_neg   (acc_neg),
    .mem_ready (mem_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mar_write (mar_write),
    .mar_src   (mar_src),
    .mbr_write (mbr_write),
    .mbr_src   (mbr_src),
    .ir_write  (ir_write),
    .pc_inc    (pc_inc),
    .pc_write  (pc_write),
    .acc_write (acc_write),
    .acc_src   (acc_src),
    .alu_op    (alu_op),
    .retire    (retire),
    .halted    (halted),
    .illegal   (illegal),
    .state     (state)
  );

  logic [17:0] all_outs;
  assign all_outs = {mem_read, mem_write, mar_write, mar_src, mbr_write, mbr_src, ir_write,
                     pc_inc, pc_write, acc_write, acc_src, alu_op, retire, halted, illegal};

  // ---------------- datapath / memory model ----------------
  logic [15:0] prog [0:4095];
  logic [15:0] mem  [0:4095];
  logic [15:0] pc, acc, mbr, ir, init_acc;
  logic [11:0] mar;
  int          cyc = 0;
  int          stall_lo = 1000;
  int          stall_hi = 0;

  assign ir_opcode = ir[15:12];
  assign acc_zero  = (acc == 16'h0000);
  assign acc_neg   = acc[15];
  assign mem_ready = !((cyc >= stall_lo) && (cyc <= stall_hi));

  function automatic logic [15:0] alu_model(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SHL: return a << 1;
      ALU_SHR: return a >> 1;
      default: return a;
    endcase
  endfunction

  always @(posedge clock) begin
    cyc <= start ? 1 : cyc + 1;
    if (!reset_n) begin
      for (int i = 0; i < 4096; i++) mem[i] <= prog[i];
      pc  <= 16'h0000;
      acc <= init_acc;
      mbr <= 16'h0000;
      ir  <= 16'h0000;
      mar <= 12'h000;
    end else begin
      if (mar_write) mar <= mar_src ? ir[11:0] : pc[11:0];
      if (mbr_write) mbr <= mbr_src ? acc : mem[mar];
      if (ir_write) ir <= mbr;
      if (pc_write) pc <= {4'h0, ir[11:0]};
      else if (pc_inc) pc <= pc + 16'd1;
      if (acc_write) acc <= acc_src ? alu_model(alu_op, acc, mbr) : mbr;
      if (mem_write && mem_ready) mem[mar] <= mbr;
    end
  end

  // ---------------- checking ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Retire record: {cycle, pc_write, acc_write, acc_src, alu_op, mem_write}
  function automatic logic [15:0] ret_vec(input int c, input logic pw, input logic aw,
                                          input logic as, input logic [3:0] op, input logic mw);
    return {8'(c), pw, aw, as, op, mw};
  endfunction

  always @(negedge clock) begin
    if (reset_n && retire) begin
      if (exp_q.size() == 0) begin
        check("unexpected_retire", {16'h0, 8'(cyc), 8'h0}, 32'h0);
      end else begin
        exp_item = exp_q.pop_front();
        check("retire", {16'h0, ret_vec(cyc, pc_write, acc_write, acc_src, alu_op, mem_write)},
              {16'h0, exp_item});
      end
    end
    if (reset_n && (mem_read || mem_write))
      check("mem_rw_mutex", {31'h0, mem_read & mem_write}, 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic clear_prog();
    for (int i = 0; i < 4096; i++) prog[i] = 16'hF000;
    stall_lo = 1000;
    stall_hi = 0;
  endtask

  task automatic do_reset(input logic [15:0] a0);
    init_acc = a0;
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    int k;
    k = 0;
    while ((cyc != n) && (k < 200)) begin
      @(negedge clock);
      k++;
    end
    if (cyc != n) check("wait_cyc_timeout", cyc, n);
  endtask

  task automatic wait_halt();
    int k;
    k = 0;
    while (!halted && (k < 100)) begin
      @(negedge clock);
      k++;
    end
    check("halt_reached", {31'h0, halted}, 32'h1);
    check("exp_q_drained", exp_q.size(), 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    clear_prog();
    init_acc = 16'h0000;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {14'h0, all_outs}, 32'h0);
    check("reset_state", {28'h0, state}, {28'h0, ST_IDLE});
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_without_start", {28'h0, state}, {28'h0, ST_IDLE});

    // LOAD 0x010 then HALT
    clear_prog();
    prog[0] = 16'h1010; prog[1] = 16'hF000; prog[16'h10] = 16'h0007;
    do_reset(16'h1234);
    exp_q.push_back(ret_vec(7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_cyc(7);
    check("load_pc_after_fetch", {16'h0, pc}, 32'h1);
    wait_halt();
    check("load_acc", {16'h0, acc}, 32'h7);
    check("load_pc_final", {16'h0, pc}, 32'h2);

    // ADD with two wait states in EXEC_MEM: 10 + 5
    clear_prog();
    prog[0] = 16'h3040; prog[1] = 16'hF000; prog[16'h40] = 16'h0005;
    stall_lo = 6; stall_hi = 7;
    do_reset(16'h000A);
    exp_q.push_back(ret_vec(9, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(13, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("add_acc", {16'h0, acc}, 32'hF);

    // JMPZ taken
    clear_prog();
    prog[0] = 16'hB020; prog[16'h20] = 16'hF000;
    do_reset(16'h0000);
    exp_q.push_back(ret_vec(4, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(8, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("jmpz_taken_pc", {16'h0, pc}, 32'h21);

    // JMPZ not taken
    clear_prog();
    prog[0] = 16'hB020; prog[1] = 16'hF000;
    do_reset(16'h0005);
    exp_q.push_back(ret_vec(4, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(8, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("jmpz_untaken_pc", {16'h0, pc}, 32'h2);

    // JMPN taken on negative ACC
    clear_prog();
    prog[0] = 16'hC005; prog[5] = 16'hF000;
    do_reset(16'h8000);
    exp_q.push_back(ret_vec(4, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(8, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("jmpn_taken_pc", {16'h0, pc}, 32'h6);

    // STORE ACC to 0x030
    clear_prog();
    prog[0] = 16'h2030; prog[1] = 16'hF000;
    do_reset(16'hBEEF);
    exp_q.push_back(ret_vec(6, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1));
    exp_q.push_back(ret_vec(10, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_cyc(5);
    check("store_exec_addr", {27'h0, mar_write, mar_src, mbr_write, mbr_src, mem_read},
          32'b11110);
    wait_cyc(6);
    check("store_exec_mem", {30'h0, mem_write, mem_read}, 32'b10);
    wait_halt();
    check("store_mem", {16'h0, mem[12'h030]}, 32'hBEEF);

    // SHL: 3 -> 6
    clear_prog();
    prog[0] = 16'h8000; prog[1] = 16'hF000;
    do_reset(16'h0003);
    exp_q.push_back(ret_vec(5, 1'b0, 1'b1, 1'b1, 4'b0100, 1'b0));
    exp_q.push_back(ret_vec(9, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("shl_acc", {16'h0, acc}, 32'h6);

    // Reserved opcode D halts without retiring; start clears illegal and resumes
    clear_prog();
    prog[0] = 16'hD000; prog[1] = 16'hF000;
    do_reset(16'h0000);
    pulse_start();
    wait_cyc(5);
    check("illegal_halt", {29'h0, halted, illegal, retire}, 32'b110);
    exp_q.push_back(ret_vec(4, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    check("illegal_cleared", {31'h0, illegal}, 32'h0);
    check("resume_fetch", {27'h0, state, mar_write}, {27'h0, ST_FETCH_ADDR, 1'b1});
    wait_halt();

    // Reset asserted while FETCH_MEM waits on memory
    clear_prog();
    prog[0] = 16'h1010; prog[1] = 16'hF000; prog[16'h10] = 16'h0007;
    stall_lo = 2; stall_hi = 50;
    do_reset(16'h0000);
    pulse_start();
    wait_cyc(3);
    check("fetch_mem_waiting", {27'h0, state, mem_read}, {27'h0, ST_FETCH_MEM, 1'b1});
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {14'h0, all_outs}, 32'h0);
    check("async_reset_state", {28'h0, state}, {28'h0, ST_IDLE});
    stall_lo = 1000; stall_hi = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    check("post_reset_idle", {14'h0, all_outs, state}, {14'h0, 18'h0, ST_IDLE});
    exp_q.push_back(ret_vec(7, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0));
    exp_q.push_back(ret_vec(11, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0));
    pulse_start();
    wait_halt();
    check("post_reset_load_acc", {16'h0, acc}, 32'h7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
